fft_stage_sequencer: RTL

Time-multiplexing controller for the 16-point radix-2 FFT core. It drives a single shared butterfly stage through all four pair patterns (stride 8, 4, 2, 1) in order, selecting the butterfly's source (input frame or feedback register) and loading the feedback register after each stage. It sits between the frame input buffer and the output/twiddle path. A frame-level valid/ready handshake frames each transform, and a watchdog aborts the transform if the butterfly stops responding.

---
 rtl/fft_pkg.sv | 7 +
 rtl/fft_seq_wdog.sv | 18 +
 rtl/fft_stage_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/fft_pkg.sv
// fft_pkg: shared types and constants for the 16-point radix-2 FFT core.
package fft_pkg;
    localparam int FFT_N      = 16;
    localparam int FFT_STAGES = $clog2(FFT_N);
    typedef logic [1:0] pair_t;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} seq_state_t;
endpackage

// File: rtl/fft_seq_wdog.sv
// fft_seq_wdog: butterfly response watchdog; expire flags the last allowed WAIT cycle.
module fft_seq_wdog #(
    parameter int WDOG = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int W = (WDOG > 1) ? $clog2(WDOG) : 1;
    logic [W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (en) cnt <= cnt + 1'b1;
    end
    assign expire = cnt == W'(WDOG - 1);
endmodule

// File: rtl/fft_stage_sequencer.sv
// fft_stage_sequencer: steps one shared butterfly through every FFT stage of a frame.
// Define FFT_SEQ_PERF_EN to add the frame_cnt / abort_cnt performance counters.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int STAGES = FFT_STAGES,
    parameter int BF_LAT = 2,
    parameter int WDOG   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        bf_valid,
    output pair_t       bf_pair,
    output logic        bf_src_sel,
    input  logic        bf_done,
    output logic        fb_load,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        err
`ifdef FFT_SEQ_PERF_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [7:0]  abort_cnt
`endif
);
    // the watchdog window must outlast the butterfly, so a too-small WDOG is widened
    localparam int WDOG_EFF = (WDOG > BF_LAT) ? WDOG : BF_LAT + 1;

    seq_state_t state, state_d;
    pair_t      stage, stage_d;
    logic       err_q, err_d, expire, last, abort;

    fft_seq_wdog #(.WDOG(WDOG_EFF)) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (state == ISSUE),
        .en     (state == WAIT),
        .expire (expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            stage <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_d;
            stage <= stage_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        last    = stage == pair_t'(STAGES - 1);
        abort   = state == WAIT && !bf_done && expire;
        state_d = state;
        stage_d = stage;
        err_d   = err_q;
        case (state)
            IDLE: if (in_valid) begin
                state_d = ISSUE;
                stage_d = '0;
                err_d   = 1'b0;
            end
            ISSUE: state_d = WAIT;
            WAIT: if (bf_done) begin
                state_d = last ? OUT : ISSUE;
                stage_d = last ? stage : stage + 1'b1;
            end else if (expire) begin
                state_d = IDLE;
                stage_d = '0;
                err_d   = 1'b1;
            end
            OUT: if (out_ready) begin
                state_d = IDLE;
                stage_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready   = state == IDLE;
        busy       = state != IDLE;
        bf_valid   = state == ISSUE;
        bf_pair    = stage;
        bf_src_sel = (state == ISSUE || state == WAIT) && stage != '0;
        fb_load    = state == WAIT && bf_done;
        out_valid  = state == OUT;
        // the abort cycle itself already reports the error
        err        = err_q || abort;
    end

`ifdef FFT_SEQ_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
            abort_cnt <= '0;
        end else begin
            if (state == OUT && out_ready) frame_cnt <= frame_cnt + 1'b1;
            if (abort && abort_cnt != 8'hFF) abort_cnt <= abort_cnt + 1'b1;
        end
    end
`endif
endmodule
